ps2_scancode_decoder: RTL

Consumes scan-code set 2 bytes from the PS/2 keyboard controller's FIFO interface (`data`/`ready`/`nextdata_n`) and turns them into key events. Strips E0/F0 prefixes, tracks shift/caps modifiers and the currently held key, and suppresses typematic repeats. Emits one `key_valid` pulse per new key press, with its scan code and ASCII translation. Sits between the keyboard controller and display/console logic.

---
 rtl/ps2_scancode_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan byte decoder: pops one byte every 3 cycles (IDLE/ACK/PROC), strips E0/F0/E1 prefixes,
// tracks shift/caps/held key and emits one key_valid pulse per new press; ready is only sampled in IDLE.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       key_held,
  output logic       shift,
  output logic       caps,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, ACK, PROC} state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_p;
  logic       brk_p;
  logic       lshift;
  logic       rshift;
  logic       caps_dn;
  logic       held_ext;
  logic [7:0] held_code;
  logic       same_as_held;

  assign shift        = lshift | rshift;
  assign same_as_held = (held_ext == ext_p) && (held_code == byte_r);

  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic upper);
    logic [7:0] base;
    logic [7:0] a;
    base = upper ? 8'h41 : 8'h61;
    a    = 8'h00;
    case (c)
      8'h1C: a = base + 8'd0;
      8'h32: a = base + 8'd1;
      8'h21: a = base + 8'd2;
      8'h23: a = base + 8'd3;
      8'h24: a = base + 8'd4;
      8'h2B: a = base + 8'd5;
      8'h34: a = base + 8'd6;
      8'h33: a = base + 8'd7;
      8'h43: a = base + 8'd8;
      8'h3B: a = base + 8'd9;
      8'h42: a = base + 8'd10;
      8'h4B: a = base + 8'd11;
      8'h3A: a = base + 8'd12;
      8'h31: a = base + 8'd13;
      8'h44: a = base + 8'd14;
      8'h4D: a = base + 8'd15;
      8'h15: a = base + 8'd16;
      8'h2D: a = base + 8'd17;
      8'h1B: a = base + 8'd18;
      8'h2C: a = base + 8'd19;
      8'h3C: a = base + 8'd20;
      8'h2A: a = base + 8'd21;
      8'h1D: a = base + 8'd22;
      8'h22: a = base + 8'd23;
      8'h35: a = base + 8'd24;
      8'h1A: a = base + 8'd25;
      8'h45: a = 8'h30;
      8'h16: a = 8'h31;
      8'h1E: a = 8'h32;
      8'h26: a = 8'h33;
      8'h25: a = 8'h34;
      8'h2E: a = 8'h35;
      8'h36: a = 8'h36;
      8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      nextdata_n  <= 1'b1;
      byte_r      <= 8'h00;
      ext_p       <= 1'b0;
      brk_p       <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      caps        <= 1'b0;
      caps_dn     <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
      key_held    <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_ascii   <= 8'h00;
      press_count <= 8'h00;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= ACK;
          end
        end
        ACK: begin
          nextdata_n <= 1'b1;
          state      <= PROC;
        end
        PROC: begin
          state <= IDLE;
          case (byte_r)
            8'hE0: ext_p <= 1'b1;
            8'hF0: brk_p <= 1'b1;
            8'hE1: begin
              ext_p <= 1'b0;
              brk_p <= 1'b0;
            end
            default: begin
              ext_p <= 1'b0;
              brk_p <= 1'b0;
              if (!ext_p && (byte_r == 8'h12)) begin
                lshift <= ~brk_p;
              end else if (!ext_p && (byte_r == 8'h59)) begin
                rshift <= ~brk_p;
              end else if (!ext_p && (byte_r == 8'h58)) begin
                // caps_dn keeps typematic repeats of caps-lock from re-toggling
                if (brk_p) begin
                  caps_dn <= 1'b0;
                end else if (!caps_dn) begin
                  caps    <= ~caps;
                  caps_dn <= 1'b1;
                end
              end else if (brk_p) begin
                if (same_as_held) key_held <= 1'b0;
              end else if (!(key_held && same_as_held)) begin
                key_code    <= byte_r;
                key_ext     <= ext_p;
                key_ascii   <= ext_p ? 8'h00 : to_ascii(byte_r, shift ^ caps);
                key_held    <= 1'b1;
                held_ext    <= ext_p;
                held_code   <= byte_r;
                press_count <= press_count + 8'd1;
                key_valid   <= 1'b1;
              end
            end
          endcase
        end
        default: begin
          state      <= IDLE;
          nextdata_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
